// File: rtl/adn_scroll_ctrl.sv
// adn_scroll_ctrl: FIFO-buffered nucleotide code stream scrolled right-to-left across 7-segment digits
module adn_scroll_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              pause,
    input  logic                              in_valid,
    input  logic [2:0]                        in_code,
    output logic                              in_ready,
    output logic [3*NUM_DIGITS-1:0]           digit_codes,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy,
    output logic                              step
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(NUM_DIGITS + 1);
    localparam int DW = 3 * NUM_DIGITS;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [2:0]     mem_q [FIFO_DEPTH];
    logic [2:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [BW-1:0]  blank_q, blank_d;
    logic [DW-1:0]  digits_q, digits_d;
    logic           step_q, step_d;
    logic           push, pop, step_edge;
    logic [2:0]     shift_code;

    assign in_ready    = count_q < DEPTH_C;
    assign digit_codes = digits_q;
    assign fifo_count  = count_q;
    assign busy        = state_q != IDLE;
    assign step        = step_q;

    // Next-state: FIFO push/pop, tick divider, scroll FSM; clear overrides everything
    always_comb begin
        push       = in_valid & in_ready & ~clear;
        step_edge  = (state_q != IDLE) & ~pause & ~clear & (tick_q == TICK_LAST);
        pop        = step_edge & (count_q != '0);
        shift_code = pop ? mem_q[rd_q] : 3'b000;
        mem_d      = mem_q;
        if (push) mem_d[wr_q] = in_code;
        wr_d       = push ? wr_q + AW'(1) : wr_q;
        rd_d       = pop ? rd_q + AW'(1) : rd_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        state_d    = state_q;
        tick_d     = tick_q;
        blank_d    = blank_q;
        digits_d   = digits_q;
        step_d     = step_edge;
        if (state_q == IDLE) begin
            tick_d = '0;
            if (count_q != '0 && !pause) state_d = RUN;
        end else if (!pause) begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
        end
        if (step_edge) begin
            digits_d      = digits_q << 3;
            digits_d[2:0] = shift_code;
            if (pop) begin
                blank_d = '0;
                state_d = (count_q == CW'(1) && !push) ? DRAIN : RUN;
            end else begin
                blank_d = blank_q + BW'(1);
                if (blank_q == BLANK_LAST) state_d = IDLE;
            end
        end
        if (clear) begin
            wr_d     = '0;
            rd_d     = '0;
            count_d  = '0;
            state_d  = IDLE;
            tick_d   = '0;
            blank_d  = '0;
            digits_d = '0;
            step_d   = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            tick_q   <= '0;
            blank_q  <= '0;
            digits_q <= '0;
            step_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            state_q  <= state_d;
            tick_q   <= tick_d;
            blank_q  <= blank_d;
            digits_q <= digits_d;
            step_q   <= step_d;
        end
    end
endmodule

// File: tb/tb_adn_scroll_ctrl.sv
// tb_adn_scroll_ctrl: randomized and directed checks of adn_scroll_ctrl against a queue-based model
module tb_adn_scroll_ctrl;
    localparam int ND    = 4;
    localparam int DEPTH = 4;
    localparam int TD    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        pause = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_code = 3'd0;
    logic        in_ready, busy, step;
    logic [11:0] digit_codes;
    logic [2:0]  fifo_count;
    logic [17:0] dut_vec;

    int n_chk = 0;
    int n_fail = 0;

    logic [2:0] m_q[$];
    logic [2:0] m_dig[ND];
    int         m_tick, m_blanks;
    bit         m_busy, m_step;

    always #5 clk = ~clk;

    adn_scroll_ctrl #(.NUM_DIGITS(ND), .FIFO_DEPTH(DEPTH), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .pause(pause),
        .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
        .digit_codes(digit_codes), .fifo_count(fifo_count), .busy(busy), .step(step)
    );

    assign dut_vec = {digit_codes, fifo_count, busy, step, in_ready};

    task automatic model_reset();
        m_q.delete();
        foreach (m_dig[k]) m_dig[k] = 3'd0;
        m_tick = 0;
        m_blanks = 0;
        m_busy = 0;
        m_step = 0;
    endtask

    // Display is a shift register of codes; busy means "scrolling", which ends after ND blank shifts
    task automatic model_step();
        int sz;
        bit stepnow, nb;
        logic [2:0] code;
        if (clear) begin
            model_reset();
            return;
        end
        sz = m_q.size();
        stepnow = m_busy && !pause && m_tick == TD - 1;
        nb = m_busy;
        if (stepnow) begin
            if (sz > 0) begin
                code = m_q.pop_front();
                m_blanks = 0;
            end else begin
                code = 3'd0;
                m_blanks++;
                if (m_blanks == ND) nb = 0;
            end
            for (int k = ND - 1; k > 0; k--) m_dig[k] = m_dig[k-1];
            m_dig[0] = code;
        end
        if (m_busy && !pause) m_tick = (m_tick + 1) % TD;
        if (!m_busy && !pause && sz > 0) nb = 1;
        if (in_valid && sz < DEPTH) m_q.push_back(in_code);
        m_busy = nb;
        m_step = stepnow;
    endtask

    function automatic logic [17:0] exp_vec();
        logic [11:0] d;
        for (int k = 0; k < ND; k++) d[3*k +: 3] = m_dig[k];
        return {d, 3'(m_q.size()), m_busy, m_step, m_q.size() < DEPTH};
    endfunction

    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if (dut_vec !== 18'h00001) begin
            n_fail++;
            $display("FAIL reset_hold: dut=%h exp=%h", dut_vec, 18'h00001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) begin
            cycle();
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_release: dut=%h exp=%h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_scroll();
        logic [2:0]  codes[4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [11:0] seq[4] = '{12'h001, 12'h00A, 12'h053, 12'h29C};
        int nsteps = 0;
        int last = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_code = codes[i];
            cycle();
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL scroll_push: dut=%h exp=%h", dut_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        for (int c = 1; c <= 40 && nsteps < 4; c++) begin
            cycle();
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL scroll_cycle: dut=%h exp=%h", dut_vec, exp_vec());
            end
            if (step) begin
                n_chk++;
                if (digit_codes !== seq[nsteps]) begin
                    n_fail++;
                    $display("FAIL scroll_digits: dut=%h exp=%h", digit_codes, seq[nsteps]);
                end
                if (nsteps > 0) begin
                    n_chk++;
                    if (c - last != TD) begin
                        n_fail++;
                        $display("FAIL scroll_period: got=%0d exp=%0d", c - last, TD);
                    end
                end
                last = c;
                nsteps++;
            end
        end
        if (nsteps < 4) begin
            n_fail++;
            $display("FAIL scroll_timeout: steps=%0d exp=4", nsteps);
        end
    endtask

    task automatic test_drain();
        int nsteps = 0;
        for (int c = 0; c < 40 && nsteps < 4; c++) begin
            cycle();
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain_cycle: dut=%h exp=%h", dut_vec, exp_vec());
            end
            if (step) nsteps++;
        end
        n_chk++;
        if (nsteps < 4 || busy !== 1'b0 || digit_codes !== 12'h000) begin
            n_fail++;
            $display("FAIL drain_end: steps=%0d busy=%b digits=%h exp 4/0/000", nsteps, busy, digit_codes);
        end
    endtask

    task automatic test_pause_fill();
        logic [2:0] c5[5];
        int idx = 0;
        bit acc;
        foreach (c5[i]) c5[i] = 3'($urandom_range(0, 7));
        pause = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_code = c5[idx];
            acc = in_ready;
            cycle();
            if (acc) idx++;
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_fill_cycle: dut=%h exp=%h", dut_vec, exp_vec());
            end
        end
        n_chk++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0 || idx != 4) begin
            n_fail++;
            $display("FAIL pause_fill_full: count=%0d ready=%b accepted=%0d exp 4/0/4", fifo_count, in_ready, idx);
        end
        pause = 1'b0;
        for (int c = 0; c < 30 && idx < 5; c++) begin
            acc = in_ready;
            cycle();
            if (acc) idx++;
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_fill_resume: dut=%h exp=%h", dut_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        if (idx < 5) begin
            n_fail++;
            $display("FAIL pause_fill_timeout: accepted=%0d exp=5", idx);
        end
        for (int c = 0; c < 100 && busy; c++) begin
            cycle();
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_fill_drain: dut=%h exp=%h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_pause_mid();
        logic [11:0] frozen;
        bit seen = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_code = 3'($urandom_range(1, 7));
            cycle();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            cycle();
            seen = step;
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_mid_run: dut=%h exp=%h", dut_vec, exp_vec());
            end
        end
        cycle();
        pause = 1'b1;
        frozen = digit_codes;
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_chk++;
            if (step !== 1'b0 || digit_codes !== frozen || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_mid_frozen: dut=%h exp=%h digits_before=%h", dut_vec, exp_vec(), frozen);
            end
        end
        pause = 1'b0;
        for (int c = 0; c < 60 && busy; c++) begin
            cycle();
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_mid_resume: dut=%h exp=%h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_clear();
        bit seen = 0;
        in_valid = 1'b1;
        in_code = 3'b011;
        cycle();
        in_valid = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cycle();
            seen = step;
        end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_code = 3'($urandom_range(1, 7));
            cycle();
        end
        n_chk++;
        if (dut_vec !== exp_vec() || fifo_count !== 3'd3) begin
            n_fail++;
            $display("FAIL clear_setup: dut=%h exp=%h", dut_vec, exp_vec());
        end
        clear = 1'b1;
        in_valid = 1'b1;
        in_code = 3'b111;
        cycle();
        clear = 1'b0;
        in_valid = 1'b0;
        pause = 1'b0;
        n_chk++;
        if (dut_vec !== 18'h00001 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL clear_result: dut=%h exp=%h", dut_vec, 18'h00001);
        end
        repeat (3) begin
            cycle();
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL clear_after: dut=%h exp=%h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        in_valid = 1'b1;
        in_code = 3'b010;
        cycle();
        in_valid = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cycle();
            seen = step;
        end
        cycle();
        n_chk++;
        if (dut_vec !== exp_vec() || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_drain: dut=%h exp=%h", dut_vec, exp_vec());
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (dut_vec !== 18'h00001 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_mid_async: dut=%h exp=%h", dut_vec, 18'h00001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_code = 3'b111;
        cycle();
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cycle();
            seen = step;
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_cycle: dut=%h exp=%h", dut_vec, exp_vec());
            end
        end
        n_chk++;
        if (!seen || digit_codes !== 12'h007) begin
            n_fail++;
            $display("FAIL reset_mid_first_step: step_seen=%b digits=%h exp=007", seen, digit_codes);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_code = 3'($urandom_range(0, 7));
            pause = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 99) == 0);
            cycle();
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: dut=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scroll();
        test_drain();
        test_pause_fill();
        test_pause_mid();
        test_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
